ahb_lite_interconnect: RTL and testbench
========================================

Name: ahb_lite_interconnect

Overview:
- Single-master AHB-Lite decoder and response multiplexer between the Cortex-M0 bus master and the memory-mapped slaves: RAM slave (S0), GPIO (S1), timer (S2).
- Decodes the address phase into one-hot slave selects.
- Registers the data-phase owner and steers that slave's HRDATA, HREADY and HRESP back to the master.
- Contains a built-in default slave that returns a two-cycle ERROR response for unmapped accesses, and a saturating error counter for debug.

Parameters:
- NUM_SLAVES, 3, number of external slave ports.
- S0_BASE, 32'h2000_0000, RAM base address.
- S0_MASK, 32'hFFFF_0000, RAM decode mask (64 KB).
- S1_BASE, 32'h4000_0000, GPIO base address.
- S1_MASK, 32'hFFFF_F000, GPIO decode mask (4 KB).
- S2_BASE, 32'h4000_1000, timer base address.
- S2_MASK, 32'hFFFF_F000, timer decode mask (4 KB).
- ERRCNT_W, 8, error counter width.

Ports:
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HWRITE  in  1  master write flag.
- HSIZE  in  3  master transfer size; passed through.
- HBURST  in  3  master burst type; passed through.
- HPROT  in  4  master protection; passed through.
- HMASTLOCK  in  1  master lock; passed through.
- HWDATA  in  32  master write data; passed through.
- HRDATA  out  32  read data to master.
- HREADY  out  1  bus ready to master; also fanned out as slave HREADY input.
- HRESP  out  2  response to master (00 OKAY, 01 ERROR).
- HSEL_S  out  NUM_SLAVES  one-hot slave selects.
- HRDATA_S  in  32*NUM_SLAVES  flattened slave read data; slave i at bits [32*i+31:32*i].
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready response.
- HRESP_S  in  2*NUM_SLAVES  flattened per-slave responses.
- ERR_COUNT  out  ERRCNT_W  saturating count of default-slave ERROR responses.

Behaviour:
- Decode (combinational, address phase): match_i = ((HADDR & Si_MASK) == Si_BASE).
  - Overlapping matches: lowest index wins.
  - HSEL_S is one-hot or zero, driven regardless of HTRANS; slaves qualify with HTRANS.
  - no_match = no match AND HTRANS[1]=1.
- Data-phase owner register dp_sel: one-hot over {S0..S2, DEFAULT, NONE}.
  - Loads only when HREADY=1 at the rising edge.
  - Loads Si if matched, DEFAULT if no_match, NONE otherwise (including unmapped IDLE/BUSY).
- Response mux (combinational from dp_sel):
  - Si: HRDATA=HRDATA_S[i], HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
  - NONE: HRDATA=0, HREADY=1, HRESP=OKAY (zero-wait OKAY for IDLE/BUSY).
  - DEFAULT: driven by the default-slave FSM; HRDATA=0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 when HREADY=1 and no_match.
  - DS_ERR1: HREADY=0, HRESP=ERROR; always -> DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=ERROR. Goes -> DS_ERR1 if a new no_match is sampled this cycle (back-to-back unmapped accesses), else -> DS_IDLE.
- ERR_COUNT increments by 1 on each entry to DS_ERR1 and saturates at all-ones (no wrap).
- Slave wait states: while the selected HREADYOUT_S=0, dp_sel holds and the master address is held by protocol; no new decode is registered.
- Slave ERROR responses (two-cycle, from the slave) pass through unmodified and do not count in ERR_COUNT.
- Reset (HRESET=1 at an edge), including mid-transfer:
  - dp_sel=NONE, FSM=DS_IDLE, ERR_COUNT=0.
  - Outputs settle to HREADY=1, HRESP=OKAY, HRDATA=0.
  - Any in-flight data phase is abandoned.
- Latency: zero added cycles for mapped slaves; unmapped NONSEQ/SEQ takes exactly 2 data-phase cycles.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and HRESP encodings (OKAY/ERROR).
  - Default address map constants (S*_BASE/S*_MASK).
  - Default-slave state enum.
- One sub-module: ahb_default_slave. Contains the FSM and ERR_COUNT; inputs HCLK, HRESET, sel (no_match gated by HREADY); outputs hreadyout and hresp.

Test Plan:
- Reset, then IDLE on HTRANS -> HREADY=1, HRESP=00, HRDATA=0, HSEL_S=000, ERR_COUNT=0.
- NONSEQ read at 0x2000_0010 with S0 returning HRDATA_S[0]=32'hDEAD_BEEF and one wait state -> HSEL_S=001 in the address phase; next cycle HREADY=0; following cycle HREADY=1, HRDATA=DEAD_BEEF, HRESP=00.
- NONSEQ write at 0x4000_1004 -> HSEL_S=100; the data phase mirrors HREADYOUT_S[2]; S0 and S1 are never selected.
- NONSEQ at unmapped 0x6000_0000 -> data-phase cycle 1: HREADY=0, HRESP=01; cycle 2: HREADY=1, HRESP=01; ERR_COUNT=1.
- Back-to-back unmapped NONSEQs, then 256 more -> ERR2->ERR1 transition observed with no DS_IDLE cycle between them; ERR_COUNT saturates at 255.
- Assert HRESET during S0 wait state and during DS_ERR1 -> next cycle HREADY=1, HRESP=00, ERR_COUNT=0, dp_sel=NONE.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, default address map and default-slave state type
// for the single-master interconnect.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] DEF_S0_BASE = 32'h2000_0000;
  localparam logic [31:0] DEF_S0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_S1_BASE = 32'h4000_0000;
  localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_F000;
  localparam logic [31:0] DEF_S2_BASE = 32'h4000_1000;
  localparam logic [31:0] DEF_S2_MASK = 32'hFFFF_F000;

  typedef enum logic [1:0] {
    DsIdle,
    DsErr1,
    DsErr2
  } ds_state_e;

endpackage

// File: rtl/ahb_lite_interconnect_if.sv
// AHB-Lite bus bundle: master-side signals plus the flattened per-slave select
// and response vectors seen by the interconnect.
interface ahb_lite_interconnect_if #(
  parameter int unsigned NUM_SLAVES = 3
);
  logic [31:0]              HADDR;
  logic [1:0]               HTRANS;
  logic                     HWRITE;
  logic [2:0]               HSIZE;
  logic [2:0]               HBURST;
  logic [3:0]               HPROT;
  logic                     HMASTLOCK;
  logic [31:0]              HWDATA;
  logic [31:0]              HRDATA;
  logic                     HREADY;
  logic [1:0]               HRESP;
  logic [NUM_SLAVES-1:0]    HSEL_S;
  logic [32*NUM_SLAVES-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]    HREADYOUT_S;
  logic [2*NUM_SLAVES-1:0]  HRESP_S;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  // Interconnect view: decode inputs and slave responses in, muxed response out.
  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP, HSEL_S
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR
// and keeps a saturating count of those responses.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                sel,
  output logic                hreadyout,
  output logic [1:0]          hresp,
  output logic [ERRCNT_W-1:0] err_count
);

  ds_state_e           state_q, state_d;
  logic [ERRCNT_W-1:0] cnt_q;

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state_q)
      DsIdle: if (sel) state_d = DsErr1;
      DsErr1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = DsErr2;
      end
      DsErr2: begin
        hresp   = HRESP_ERROR;
        state_d = sel ? DsErr1 : DsIdle;
      end
      default: state_d = DsIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= DsIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // DsErr1 always exits to DsErr2, so landing in it is always a fresh entry.
      if (state_d == DsErr1 && cnt_q != '1) cnt_q <= cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_count = cnt_q;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite address decoder and data-phase response multiplexer
// with a built-in ERROR default slave for unmapped accesses.
module ahb_lite_interconnect
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter logic [31:0] S0_BASE    = DEF_S0_BASE,
  parameter logic [31:0] S0_MASK    = DEF_S0_MASK,
  parameter logic [31:0] S1_BASE    = DEF_S1_BASE,
  parameter logic [31:0] S1_MASK    = DEF_S1_MASK,
  parameter logic [31:0] S2_BASE    = DEF_S2_BASE,
  parameter logic [31:0] S2_MASK    = DEF_S2_MASK,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_interconnect_if.slave bus,
  output logic [ERRCNT_W-1:0]   ERR_COUNT
);

  localparam logic [31:0] BASE [3] = '{S0_BASE, S1_BASE, S2_BASE};
  localparam logic [31:0] MASK [3] = '{S0_MASK, S1_MASK, S2_MASK};

  // Data-phase owner: bits [NUM_SLAVES-1:0] slaves, then DEFAULT, then NONE.
  localparam int unsigned SEL_W = NUM_SLAVES + 2;
  localparam logic [SEL_W-1:0] SEL_DEF  = {2'b01, {NUM_SLAVES{1'b0}}};
  localparam logic [SEL_W-1:0] SEL_NONE = {2'b10, {NUM_SLAVES{1'b0}}};

  logic [NUM_SLAVES-1:0] hsel;
  logic                  no_match;
  logic [SEL_W-1:0]      dp_sel_q, dp_sel_d;
  logic [31:0]           hrdata;
  logic                  hready;
  logic [1:0]            hresp;
  logic                  ds_hreadyout;
  logic [1:0]            ds_hresp;

  // Walk from the top index down so the lowest matching slave wins.
  always_comb begin
    hsel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.HADDR & MASK[i]) == BASE[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign no_match = (hsel == '0) && (bus.HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ});

  always_comb begin
    dp_sel_d = dp_sel_q;
    if (hready) begin
      if (hsel != '0)    dp_sel_d = {2'b00, hsel};
      else if (no_match) dp_sel_d = SEL_DEF;
      else               dp_sel_d = SEL_NONE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) dp_sel_q <= SEL_NONE;
    else        dp_sel_q <= dp_sel_d;
  end

  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dp_sel_q[i]) begin
        hrdata = bus.HRDATA_S[32*i +: 32];
        hready = bus.HREADYOUT_S[i];
        hresp  = bus.HRESP_S[2*i +: 2];
      end
    end
    if (dp_sel_q[NUM_SLAVES]) begin
      hready = ds_hreadyout;
      hresp  = ds_hresp;
    end
  end

  ahb_default_slave #(
    .ERRCNT_W(ERRCNT_W)
  ) u_default_slave (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .sel      (no_match & hready),
    .hreadyout(ds_hreadyout),
    .hresp    (ds_hresp),
    .err_count(ERR_COUNT)
  );

  assign bus.HSEL_S = hsel;
  assign bus.HRDATA = hrdata;
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Bench for ahb_lite_interconnect: directed bus scenarios followed by random
// traffic, all compared every cycle against a transaction-level address-map model.
module tb_ahb_lite_interconnect;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  ahb_lite_interconnect_if #(.NUM_SLAVES(3)) bus ();

  ahb_lite_interconnect dut (
    .HCLK     (clk),
    .HRESET   (rst),
    .bus      (bus),
    .ERR_COUNT(err_count)
  );

  localparam int OWN_DEF  = 3;
  localparam int OWN_NONE = 4;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: who owns the current data phase, which error cycle, and error tally.
  int owner      = OWN_NONE;
  int ds_cycle   = 0;
  int exp_err    = 0;
  bit model_ok   = 1'b0;
  bit last_ready = 1'b1;

  logic [31:0] pool [10];

  function automatic int region(logic [31:0] a);
    if (a >= 32'h2000_0000 && a <= 32'h2000_FFFF) return 0;
    if (a >= 32'h4000_0000 && a <= 32'h4000_0FFF) return 1;
    if (a >= 32'h4000_1000 && a <= 32'h4000_1FFF) return 2;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: compare outputs mid-cycle, then advance the model past the edge.
  task automatic step();
    logic [31:0] e_rdata;
    logic        e_ready;
    logic [1:0]  e_resp;
    logic [2:0]  e_sel;
    int          d;
    @(negedge clk);
    d     = region(bus.HADDR);
    e_sel = (d < 0) ? 3'b000 : 3'(1 << d);
    case (owner)
      0, 1, 2: begin
        e_rdata = bus.HRDATA_S[32*owner +: 32];
        e_ready = bus.HREADYOUT_S[owner];
        e_resp  = bus.HRESP_S[2*owner +: 2];
      end
      OWN_DEF: begin
        e_rdata = 32'h0;
        e_ready = (ds_cycle == 2);
        e_resp  = 2'b01;
      end
      default: begin
        e_rdata = 32'h0;
        e_ready = 1'b1;
        e_resp  = 2'b00;
      end
    endcase
    if (model_ok) begin
      check("hsel", 32'(bus.HSEL_S), 32'(e_sel));
      check("hready", 32'(bus.HREADY), 32'(e_ready));
      check("hresp", 32'(bus.HRESP), 32'(e_resp));
      check("hrdata", bus.HRDATA, e_rdata);
      check("err_count", 32'(err_count), 32'(exp_err));
    end
    last_ready = e_ready;
    if (rst) begin
      owner    = OWN_NONE;
      exp_err  = 0;
      model_ok = 1'b1;
    end else if (e_ready) begin
      if (d >= 0) owner = d;
      else if (bus.HTRANS[1]) begin
        owner    = OWN_DEF;
        ds_cycle = 1;
        if (exp_err < 255) exp_err++;
      end else owner = OWN_NONE;
    end else if (owner == OWN_DEF) begin
      ds_cycle = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic wr);
    bus.HADDR  = addr;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HWDATA = $urandom;
  endtask

  initial begin
    pool = '{32'h2000_0000, 32'h2000_FFFC, 32'h2001_0000, 32'h1FFF_FFFC, 32'h4000_0000,
             32'h4000_0FFC, 32'h4000_1000, 32'h4000_1FFC, 32'h4000_2000, 32'h6000_0000};
    rst             = 1'b1;
    bus.HSIZE       = 3'b010;
    bus.HBURST      = 3'b000;
    bus.HPROT       = 4'b0011;
    bus.HMASTLOCK   = 1'b0;
    bus.HRDATA_S    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.HREADYOUT_S = 3'b111;
    bus.HRESP_S     = 6'b0;
    drive(32'h0, 2'b00, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();

    // Mapped read to RAM with one slave wait state.
    drive(32'h2000_0010, 2'b10, 1'b0);
    #1 check("s0_addr_hsel", 32'(bus.HSEL_S), 32'h1);
    step();
    drive(32'h0, 2'b00, 1'b0);
    bus.HREADYOUT_S = 3'b110;
    #1 check("s0_wait_hready", 32'(bus.HREADY), 32'h0);
    step();
    bus.HREADYOUT_S = 3'b111;
    bus.HRDATA_S[31:0] = 32'hDEAD_BEEF;
    #1 check("s0_rdata", bus.HRDATA, 32'hDEAD_BEEF);
    step();

    // Timer write, slave stalls once.
    drive(32'h4000_1004, 2'b10, 1'b1);
    #1 check("s2_addr_hsel", 32'(bus.HSEL_S), 32'h4);
    step();
    drive(32'h0, 2'b00, 1'b0);
    bus.HREADYOUT_S = 3'b011;
    step();
    bus.HREADYOUT_S = 3'b111;
    step();

    // Single unmapped access: two ERROR cycles.
    drive(32'h6000_0000, 2'b10, 1'b0);
    step();
    drive(32'h0, 2'b00, 1'b0);
    #1 check("unmapped_c1_hresp", 32'(bus.HRESP), 32'h1);
    step();
    #1 check("unmapped_c2_hready", 32'(bus.HREADY), 32'h1);
    step();
    check("unmapped_errcnt", 32'(err_count), 32'd1);

    // Back-to-back unmapped NONSEQs until the counter saturates.
    drive(32'h6000_0100, 2'b10, 1'b0);
    for (int k = 0; k < 2 * 258; k++) step();
    drive(32'h0, 2'b00, 1'b0);
    step();
    step();
    check("errcnt_saturated", 32'(err_count), 32'd255);

    // Reset while RAM is stalling.
    drive(32'h2000_0040, 2'b10, 1'b0);
    step();
    drive(32'h0, 2'b00, 1'b0);
    bus.HREADYOUT_S = 3'b110;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 check("rst_wait_hready", 32'(bus.HREADY), 32'h1);
    check("rst_wait_errcnt", 32'(err_count), 32'h0);
    step();
    bus.HREADYOUT_S = 3'b111;

    // Reset during the first ERROR cycle.
    drive(32'h7000_0000, 2'b11, 1'b0);
    step();
    drive(32'h0, 2'b00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 check("rst_err_hresp", 32'(bus.HRESP), 32'h0);
    check("rst_err_hrdata", bus.HRDATA, 32'h0);
    step();

    // Random traffic; the address only moves after a ready cycle.
    for (int c = 0; c < 400; c++) begin
      if (last_ready) begin
        int p;
        p = $urandom_range(0, 10);
        drive((p == 10) ? 32'($urandom) : pool[p], 2'($urandom_range(0, 3)), 1'($urandom));
      end
      for (int s = 0; s < 3; s++) begin
        bus.HREADYOUT_S[s] = ($urandom_range(0, 3) != 0);
        bus.HRESP_S[2*s +: 2] = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      end
      bus.HRDATA_S = {32'($urandom), 32'($urandom), 32'($urandom)};
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
